// File: rtl/pc_unit_pkg.sv
// rtl/pc_unit_pkg.sv - pc_unit shared constants: FSM encodings, PC increment, alignment mask
package pc_unit_pkg;

  localparam logic [1:0] ST_BOOT = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_HALT = 2'd2;

  localparam int unsigned PC_INC        = 4;
  localparam logic [1:0]  PC_ALIGN_MASK = 2'b11;

endpackage

// File: rtl/pc_ras.sv
// rtl/pc_ras.sv - circular return-address stack; a push when full overwrites the oldest entry
module pc_ras #(
  parameter int DEPTH = 4,
  parameter int NB    = 32
) (
  input  logic          clk,
  input  logic          i_rst_n,
  input  logic          i_push,
  input  logic          i_pop,
  input  logic [NB-1:0] i_data,
  output logic [NB-1:0] o_top,
  output logic          o_empty,
  output logic          o_full
);

  localparam int AW = $clog2(DEPTH);

  logic [NB-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW:0]   r_count;
  logic [AW-1:0] w_top_idx;

  assign w_top_idx = r_wr_ptr - AW'(1);
  assign o_top     = r_mem[w_top_idx];
  assign o_empty   = (r_count == '0);
  assign o_full    = (r_count == (AW+1)'(DEPTH));

  // Push together with pop reuses the slot just freed, so pointer and count stay put
  always_ff @(posedge clk) begin
    if (i_push) r_mem[i_pop ? w_top_idx : r_wr_ptr] <= i_data;
  end

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else if (i_push && !i_pop) begin
      r_wr_ptr <= r_wr_ptr + AW'(1);
      if (!o_full) r_count <= r_count + (AW+1)'(1);
    end else if (i_pop && !i_push) begin
      r_wr_ptr <= w_top_idx;
      r_count  <= r_count - (AW+1)'(1);
    end
  end

endmodule

// File: rtl/pc_unit.sv
// rtl/pc_unit.sv - fetch PC generator with BOOT/RUN/HALT FSM; RAS built only when PC_UNIT_RAS_EN is defined
module pc_unit
  import pc_unit_pkg::*;
#(
  parameter int               NB_PC        = 32,
  parameter logic [NB_PC-1:0] RESET_VECTOR = '0,
  parameter int               RAS_DEPTH    = 4
) (
  input  logic             clk,
  input  logic             i_rst_n,
  input  logic             i_stall,
  input  logic             i_redirect,
  input  logic [NB_PC-1:0] i_redirect_pc,
  input  logic             i_halt,
  input  logic             i_resume,
  input  logic             i_call,
  input  logic             i_ret,
  output logic [NB_PC-1:0] o_pc,
  output logic [NB_PC-1:0] o_pc_seq,
  output logic             o_valid,
  output logic             o_halted,
  output logic             o_ras_empty
);

  logic [1:0]       r_state;
  logic [1:0]       w_state_nxt;
  logic [NB_PC-1:0] r_pc;
  logic [NB_PC-1:0] w_pc_nxt;
  logic [NB_PC-1:0] w_pc_seq;
  logic [NB_PC-1:0] w_redirect_pc;
  logic [NB_PC-1:0] w_ras_top;
  logic             w_ras_empty;
  logic             w_advance;
  logic             w_pop;

  assign w_pc_seq      = r_pc + NB_PC'(PC_INC);
  assign w_redirect_pc = i_redirect_pc & ~NB_PC'(PC_ALIGN_MASK);
  assign w_advance     = (r_state == ST_RUN) & ~i_redirect & ~i_halt & ~i_stall;
  assign w_pop         = w_advance & i_ret & ~w_ras_empty;

`ifdef PC_UNIT_RAS_EN
  logic w_push;
  logic w_unused_full;

  assign w_push = w_advance & i_call;

  pc_ras #(
    .DEPTH (RAS_DEPTH),
    .NB    (NB_PC)
  ) u_ras (
    .clk     (clk),
    .i_rst_n (i_rst_n),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_data  (w_pc_seq),
    .o_top   (w_ras_top),
    .o_empty (w_ras_empty),
    .o_full  (w_unused_full)
  );
`else
  logic w_unused_call;

  assign w_unused_call = i_call;
  assign w_ras_top     = '0;
  assign w_ras_empty   = 1'b1;
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    case (r_state)
      ST_BOOT: w_state_nxt = ST_RUN;
      ST_RUN: begin
        if (i_redirect) begin
          w_pc_nxt = w_redirect_pc;
          if (i_halt) w_state_nxt = ST_HALT;
        end else if (i_halt) begin
          w_state_nxt = ST_HALT;
        end else if (!i_stall) begin
          w_pc_nxt = w_pop ? w_ras_top : w_pc_seq;
        end
      end
      ST_HALT: begin
        // A debugger "set PC" keeps the core halted; resume only applies without it
        if (i_redirect)                w_pc_nxt    = w_redirect_pc;
        else if (i_resume && !i_halt)  w_state_nxt = ST_RUN;
      end
      default: w_state_nxt = ST_BOOT;
    endcase
  end

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_BOOT;
      r_pc    <= RESET_VECTOR;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
    end
  end

  assign o_pc        = r_pc;
  assign o_pc_seq    = w_pc_seq;
  assign o_valid     = (r_state == ST_RUN);
  assign o_halted    = (r_state == ST_HALT);
  assign o_ras_empty = w_ras_empty;

endmodule

// File: tb/tb_pc_unit.sv
// tb/tb_pc_unit.sv - directed and random checks of pc_unit against a queue-based model (PC_UNIT_RAS_EN aware)
module tb_pc_unit;

  localparam int DEPTH = 4;
`ifdef PC_UNIT_RAS_EN
  localparam bit RAS_EN = 1'b1;
`else
  localparam bit RAS_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall = 1'b0, redirect = 1'b0, halt = 1'b0, resume = 1'b0, call = 1'b0, ret = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic [31:0] pc, pc_seq;
  logic        valid, halted, ras_empty;

  int n_checks = 0;
  int n_errors = 0;

  typedef enum {M_BOOT, M_RUN, M_HALT} mstate_t;
  mstate_t     m_state;
  logic [31:0] m_pc;
  logic [31:0] m_ras[$];

  always #5 clk = ~clk;

  pc_unit #(.NB_PC(32), .RESET_VECTOR(32'h0), .RAS_DEPTH(DEPTH)) dut (
    .clk           (clk),
    .i_rst_n       (rst_n),
    .i_stall       (stall),
    .i_redirect    (redirect),
    .i_redirect_pc (redirect_pc),
    .i_halt        (halt),
    .i_resume      (resume),
    .i_call        (call),
    .i_ret         (ret),
    .o_pc          (pc),
    .o_pc_seq      (pc_seq),
    .o_valid       (valid),
    .o_halted      (halted),
    .o_ras_empty   (ras_empty)
  );

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    m_state = M_BOOT;
    m_pc    = 32'h0;
    m_ras.delete();
  endfunction

  function automatic void model_step(input logic rd, input logic [31:0] rpc, input logic h,
                                     input logic rs, input logic s, input logic c, input logic r);
    logic [31:0] seq;
    seq = m_pc + 32'd4;
    case (m_state)
      M_BOOT: m_state = M_RUN;
      M_RUN: begin
        if (rd) begin
          m_pc = {rpc[31:2], 2'b00};
          if (h) m_state = M_HALT;
        end else if (h) begin
          m_state = M_HALT;
        end else if (!s) begin
          m_pc = seq;
          if (RAS_EN && r && m_ras.size() > 0) m_pc = m_ras.pop_back();
          if (RAS_EN && c) begin
            if (m_ras.size() == DEPTH) void'(m_ras.pop_front());
            m_ras.push_back(seq);
          end
        end
      end
      default: begin
        if (rd) m_pc = {rpc[31:2], 2'b00};
        else if (rs && !h) m_state = M_RUN;
      end
    endcase
  endfunction

  task automatic check_all(input string tag);
    check({tag, ".pc"}, pc, m_pc);
    check({tag, ".pc_seq"}, pc_seq, m_pc + 32'd4);
    check({tag, ".valid"}, {31'b0, valid}, {31'b0, m_state == M_RUN});
    check({tag, ".halted"}, {31'b0, halted}, {31'b0, m_state == M_HALT});
    check({tag, ".ras_empty"}, {31'b0, ras_empty}, {31'b0, (m_ras.size() == 0)});
  endtask

  // Called at a falling edge: apply inputs, clock once, return inputs to idle, compare
  task automatic cyc(input string tag, input logic rd, input logic [31:0] rpc, input logic h,
                     input logic rs, input logic s, input logic c, input logic r);
    redirect = rd; redirect_pc = rpc; halt = h; resume = rs; stall = s; call = c; ret = r;
    @(posedge clk);
    model_step(rd, rpc, h, rs, s, c, r);
    @(negedge clk);
    redirect = 0; halt = 0; resume = 0; stall = 0; call = 0; ret = 0;
    check_all(tag);
  endtask

  initial begin
    model_reset();
    repeat (2) @(negedge clk);
    check_all("reset");

    rst_n = 1'b1;
    check_all("boot");
    cyc("run0", 0, 0, 0, 0, 0, 0, 0);
    cyc("run1", 0, 0, 0, 0, 0, 0, 0);
    cyc("run2", 0, 0, 0, 0, 0, 0, 0);

    cyc("to10", 1, 32'h10, 0, 0, 0, 0, 0);
    cyc("stall_redir", 1, 32'h203, 0, 0, 1, 0, 0);
    check("stall_redir_200", pc, 32'h200);
    cyc("stall_only", 0, 0, 0, 0, 1, 0, 0);

    cyc("to40", 1, 32'h40, 0, 0, 0, 0, 0);
    cyc("halt40", 0, 0, 1, 0, 0, 0, 0);
    cyc("halt_stall_ign", 0, 0, 0, 0, 1, 1, 1);
    cyc("halt_set80", 1, 32'h80, 0, 0, 0, 0, 0);
    cyc("halt_wins", 0, 0, 1, 1, 0, 0, 0);
    cyc("resume", 0, 0, 0, 1, 0, 0, 0);
    cyc("after_resume", 0, 0, 0, 0, 0, 0, 0);
    check("seq84", pc, 32'h84);
    cyc("redir_halt", 1, 32'h123, 1, 0, 0, 0, 0);
    cyc("resume2", 0, 0, 0, 1, 0, 0, 0);

    cyc("to_top", 1, 32'hFFFF_FFFC, 0, 0, 0, 0, 0);
    cyc("wrap", 0, 0, 0, 0, 0, 0, 0);
    check("wrap_zero", pc, 32'h0);

    for (int i = 0; i < 5; i++) begin
      cyc("call_set", 1, 32'(i * 16), 0, 0, 0, 0, 0);
      cyc("call", 0, 0, 0, 0, 0, 1, 0);
    end
    cyc("call_stalled", 0, 0, 0, 0, 1, 1, 0);
    cyc("call_redir", 1, 32'h500, 0, 0, 0, 1, 1);
    for (int i = 0; i < 4; i++) cyc("ret", 0, 0, 0, 0, 0, 0, 1);
    cyc("ret_empty", 0, 0, 0, 0, 0, 0, 1);
    cyc("call_a", 0, 0, 0, 0, 0, 1, 0);
    cyc("call_ret", 0, 0, 0, 0, 0, 1, 1);
    cyc("ret_b", 0, 0, 0, 0, 0, 0, 1);

    for (int i = 0; i < 400; i++) begin
      logic rd, h, rs, s, c, r;
      logic [31:0] rpc;
      rd  = ($urandom_range(0, 99) < 10);
      h   = ($urandom_range(0, 99) < 5);
      rs  = ($urandom_range(0, 99) < 40);
      s   = ($urandom_range(0, 99) < 20);
      c   = ($urandom_range(0, 99) < 25);
      r   = ($urandom_range(0, 99) < 25);
      rpc = $urandom();
      if (m_state == M_HALT && rd) rs = 1'b0;
      cyc("rand", rd, rpc, h, rs, s, c, r);
    end

    cyc("pre_rst_run", 0, 0, 0, 1, 0, 0, 0);
    cyc("pre_rst_call", 1, 32'h600, 0, 0, 0, 0, 0);
    cyc("pre_rst_call2", 0, 0, 0, 0, 0, 1, 0);
    cyc("pre_rst_halt", 0, 0, 1, 0, 0, 0, 0);
    #2;
    stall = 1'b1; redirect = 1'b1; redirect_pc = 32'h700;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all("async_rst");
    @(negedge clk);
    stall = 1'b0; redirect = 1'b0;
    rst_n = 1'b1;
    check_all("post_rst_boot");
    cyc("post_rst_run", 0, 0, 0, 0, 0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
